// File: rtl/pbus_pkg.sv
// pbus_pkg
// Shared constants and types for the RPi parallel-bus receive front end.
//   PBUS_DATA_W      default bus word width
//   PBUS_SYNC_MIN    fewest synchroniser flops that may be configured
//   PBUS_FIFO_DEPTH  default rx FIFO depth (power of two, >= 2)
//   pbus_addr_w()    FIFO address width for a given depth
//   bus_dir_e        meaning of the bus_rnw strobe qualifier
package pbus_pkg;

  localparam int PBUS_DATA_W     = 16;
  localparam int PBUS_SYNC_MIN   = 2;
  localparam int PBUS_FIFO_DEPTH = 4;

  // Address width of a FIFO; never below 1 so slices stay legal.
  function automatic int pbus_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PBUS_FIFO_AW = pbus_addr_w(PBUS_FIFO_DEPTH);

  typedef enum logic {
    BUS_WRITE = 1'b0,
    BUS_READ  = 1'b1
  } bus_dir_e;

endpackage

// File: rtl/pbus_rx_fifo.sv
// pbus_rx_fifo
// Small synchronous FIFO carrying master write words to the command parser.
// Pointers are one bit wider than the address so full and empty are
// distinguishable; they wrap modulo 2*DEPTH.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (pointers only)
//   push, push_data  write request and word
//   pop            read request; ignored while empty
//   head_data      word at the head, 0 while empty
//   empty, full    occupancy flags
//   drop           a push this cycle is being discarded (full, no pop)
module pbus_rx_fifo
  import pbus_pkg::*;
#(
  parameter int DATA_W = PBUS_DATA_W,
  parameter int DEPTH  = PBUS_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int AW = pbus_addr_w(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic pop_ok;
  logic push_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop on an empty FIFO does nothing; a pop on a full FIFO frees the
  // slot the simultaneous push lands in, so that push is kept.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  // Storage is left unreset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/pbus_rx_front.sv
// pbus_rx_front
// Front end between the asynchronous RPi parallel-bus pins and the
// command-parser logic. Synchronises the strobe, direction and data pins,
// detects strobe rising edges, queues master writes in an rx FIFO and serves
// master reads from a one-word holding register.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   bus_clk_async         master strobe (asynchronous)
//   bus_rnw_async         1 = master reads, 0 = master writes
//   bus_data_in           pad input data
//   bus_data_out          pad output data, 0 unless bus_data_oe
//   bus_data_oe           pad output enable (1 = FPGA drives)
//   rx_data/rx_valid/rx_ready  FIFO head towards the parser
//   tx_data/tx_valid/tx_ready  word for the next master read
//   overflow              sticky: a write word was dropped, FIFO full
//   underrun              sticky: read edge with the holding register empty
module pbus_rx_front
  import pbus_pkg::*;
#(
  parameter int DATA_W      = PBUS_DATA_W,
  parameter int SYNC_STAGES = PBUS_SYNC_MIN,
  parameter int FIFO_DEPTH  = PBUS_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bus_clk_async,
  input  logic              bus_rnw_async,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              overflow,
  output logic              underrun
);

  // Chains shorter than the minimum are not metastability-safe; clamp.
  localparam int SYNC_N = (SYNC_STAGES < PBUS_SYNC_MIN) ? PBUS_SYNC_MIN : SYNC_STAGES;

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic [SYNC_N-1:0] clk_sync_reg;
  logic [SYNC_N-1:0] rnw_sync_reg;
  logic [DATA_W-1:0] data_sync_reg [SYNC_N];
  // Shifts in ones after reset; its top bit says the chain output now
  // reflects the pin rather than the reset value.
  logic [SYNC_N-1:0] fill_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg <= '0;
      rnw_sync_reg <= '0;
      fill_reg     <= '0;
      for (int i = 0; i < SYNC_N; i++) begin
        data_sync_reg[i] <= '0;
      end
    end else begin
      clk_sync_reg     <= {clk_sync_reg[SYNC_N-2:0], bus_clk_async};
      rnw_sync_reg     <= {rnw_sync_reg[SYNC_N-2:0], bus_rnw_async};
      fill_reg         <= {fill_reg[SYNC_N-2:0], 1'b1};
      data_sync_reg[0] <= bus_data_in;
      for (int i = 1; i < SYNC_N; i++) begin
        data_sync_reg[i] <= data_sync_reg[i-1];
      end
    end
  end

  logic              clk_s;
  logic              rnw_s;
  logic [DATA_W-1:0] data_s;
  logic              chain_live;

  assign clk_s      = clk_sync_reg[SYNC_N-1];
  assign rnw_s      = rnw_sync_reg[SYNC_N-1];
  assign data_s     = data_sync_reg[SYNC_N-1];
  assign chain_live = fill_reg[SYNC_N-1];

  // ---------------------------------------------------------------------
  // Edge detection and arming
  // ---------------------------------------------------------------------
  // Arming waits for a genuine low on the strobe: the zeros the chain holds
  // straight out of reset do not count, so a strobe held high across reset
  // release cannot masquerade as a fresh rising edge.
  logic              armed_reg;
  logic              clk_hist_reg;
  logic              edge_det;
  logic              edge_stb_reg;
  logic              edge_rnw_reg;
  logic [DATA_W-1:0] edge_data_reg;

  assign edge_det = armed_reg && clk_s && !clk_hist_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_reg     <= 1'b0;
      clk_hist_reg  <= 1'b0;
      edge_stb_reg  <= 1'b0;
      edge_rnw_reg  <= 1'b0;
      edge_data_reg <= '0;
    end else begin
      armed_reg     <= armed_reg || (chain_live && !clk_s);
      clk_hist_reg  <= clk_s;
      // Direction and data are registered alongside the strobe so the
      // action stage sees the values that were valid at the edge.
      edge_stb_reg  <= edge_det;
      edge_rnw_reg  <= rnw_s;
      edge_data_reg <= data_s;
    end
  end

  logic write_stb;
  logic read_stb;

  assign write_stb = edge_stb_reg && (bus_dir_e'(edge_rnw_reg) == BUS_WRITE);
  assign read_stb  = edge_stb_reg && (bus_dir_e'(edge_rnw_reg) == BUS_READ);

  // ---------------------------------------------------------------------
  // Rx FIFO
  // ---------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic fifo_drop;

  pbus_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (write_stb),
    .push_data (edge_data_reg),
    .pop       (rx_ready),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign rx_valid = !fifo_empty;

  // ---------------------------------------------------------------------
  // Holding register, output enable and sticky flags
  // ---------------------------------------------------------------------
  logic              tx_full_reg;
  logic [DATA_W-1:0] hold_reg;
  logic              oe_reg;
  logic              overflow_reg;
  logic              underrun_reg;
  logic              tx_load;

  // A read edge owns the holding register for its cycle; a new load waits.
  assign tx_ready = !tx_full_reg && !read_stb;
  assign tx_load  = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_full_reg  <= 1'b0;
      hold_reg     <= '0;
      oe_reg       <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      oe_reg <= rnw_s;
      if (fifo_drop) begin
        overflow_reg <= 1'b1;
      end
      // The word stays in hold_reg after a read edge so the pads keep
      // showing it while the master still samples; only the full flag goes.
      if (read_stb) begin
        tx_full_reg <= 1'b0;
        if (!tx_full_reg) begin
          underrun_reg <= 1'b1;
        end
      end else if (tx_load) begin
        hold_reg    <= tx_data;
        tx_full_reg <= 1'b1;
      end
    end
  end

  assign bus_data_oe  = oe_reg;
  assign bus_data_out = oe_reg ? hold_reg : '0;
  assign overflow     = overflow_reg;
  assign underrun     = underrun_reg;

  // Fifo status not needed beyond empty; kept visible for integration.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_pbus_rx_front.sv
// tb_pbus_rx_front
// Directed bench for pbus_rx_front. A transaction-level model (word queue,
// sticky flags, holding-register state, rnw pin history) is checked against
// the DUT every cycle during the clock-aligned tests; the randomised-phase
// test uses an in-order scoreboard instead.
module tb_pbus_rx_front;

  localparam int DW = 16;
  localparam int SS = 2;
  localparam int FD = 4;
  localparam int LAT = SS + 2;   // pin edge to effect, in clk cycles

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bus_clk = 1'b1;
  logic          bus_rnw = 1'b0;
  logic [DW-1:0] bus_din = '0;
  logic [DW-1:0] bus_data_out;
  logic          bus_data_oe;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          overflow;
  logic          underrun;

  pbus_rx_front #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_clk_async (bus_clk),
    .bus_rnw_async (bus_rnw),
    .bus_data_in   (bus_din),
    .bus_data_out  (bus_data_out),
    .bus_data_oe   (bus_data_oe),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  logic [DW-1:0] mq[$];        // words the parser should see, head first
  bit            m_ovf, m_unr, m_tx_full;
  logic [DW-1:0] m_hold;
  bit            s0, s1, s2;   // rnw pin as seen 1, 2, 3 clk edges ago
  int            ev_cnt;       // clk edges until a scheduled bus edge acts
  bit            ev_rnw;
  logic [DW-1:0] ev_data;
  bit            chk_en = 1'b1;
  bit            t6 = 1'b0;
  logic [DW-1:0] t6_exp[$];

  task automatic model_clear();
    mq.delete();
    m_ovf = 0; m_unr = 0; m_tx_full = 0; m_hold = '0;
    s0 = 0; s1 = 0; s2 = 0;
    ev_cnt = 0; ev_rnw = 0; ev_data = '0;
  endtask

  function automatic bit m_tx_ready();
    return !m_tx_full && !(ev_cnt == 1 && ev_rnw);
  endfunction

  always @(posedge clk) begin
    bit fire, do_pop, do_load;
    if (reset_n && chk_en) begin
      fire    = (ev_cnt == 1);
      do_load = tx_valid && m_tx_ready();
      do_pop  = rx_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (fire && !ev_rnw) begin
        if (mq.size() < FD) mq.push_back(ev_data);
        else m_ovf = 1;
      end
      if (fire && ev_rnw) begin
        if (!m_tx_full) m_unr = 1;
        m_tx_full = 0;
      end else if (do_load) begin
        m_hold = tx_data;
        m_tx_full = 1;
      end
      s2 = s1; s1 = s0; s0 = bus_rnw;
      if (ev_cnt > 0) ev_cnt--;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_valid", rx_valid, mq.size() != 0);
      chk("rx_data", rx_data, (mq.size() != 0) ? mq[0] : 16'h0);
      chk("overflow", overflow, m_ovf);
      chk("underrun", underrun, m_unr);
      chk("tx_ready", tx_ready, m_tx_ready());
      chk("oe", bus_data_oe, s2);
      chk("data_out", bus_data_out, s2 ? m_hold : 16'h0);
    end
  end

  // Scoreboard consumer for the randomised-phase test.
  always @(negedge clk) begin
    if (t6 && rx_valid && rx_ready) begin
      if (t6_exp.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL t6_extra: got word %0h, expected none", rx_data);
      end else begin
        chk("t6_rx", rx_data, t6_exp[0]);
        void'(t6_exp.pop_front());
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (clock-aligned)
  // ------------------------------------------------------------------
  task automatic bus_rise(input logic rnw, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus_rnw = rnw;
    bus_din = d;
    repeat (3) @(posedge clk);
    #1;
    bus_clk = 1'b1;
    ev_cnt  = LAT;
    ev_rnw  = rnw;
    ev_data = d;
  endtask

  task automatic bus_fall();
    repeat (5) @(posedge clk);
    #1;
    bus_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_write(input logic [DW-1:0] d);
    bus_rise(1'b0, d);
    bus_fall();
  endtask

  task automatic load_tx(input logic [DW-1:0] d);
    bit done;
    done = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    tx_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL tx_load_timeout: tx_ready never rose for %0h", d);
    end
  endtask

  task automatic pop_expect(input logic [DW-1:0] d);
    @(posedge clk); #1;
    chk("pop_word", rx_data, d);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_data_out", bus_data_out, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_flags", {overflow, underrun}, 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();

    // 1: strobe held high through reset release -> no word
    #2;
    chk("t1_reset_tx_ready", tx_ready, 1);
    chk("t1_reset_rx_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t1_no_spurious", rx_valid, 0);
    bus_clk = 1'b0;
    repeat (6) @(posedge clk);
    bus_rise(1'b0, 16'h1234);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("t1_not_yet", rx_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 16'h1234);
    bus_fall();
    pop_expect(16'h1234);
    $display("test1 strobe-through-reset and first write done");

    // 2: five writes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) bus_write(DW'(i));
    @(posedge clk); #1;
    chk("t2_overflow", overflow, 1);
    for (int i = 1; i <= 4; i++) pop_expect(DW'(i));
    @(posedge clk); #1;
    chk("t2_drained", rx_valid, 0);
    $display("test2 overflow and in-order drain done");

    // 3: full FIFO, push and pop land in the same cycle
    pulse_reset(3);
    for (int i = 0; i < 4; i++) bus_write(16'h0010 + DW'(i));
    bus_rise(1'b0, 16'h0014);
    repeat (LAT - 1) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("t3_no_overflow", overflow, 0);
    bus_fall();
    for (int i = 1; i <= 4; i++) pop_expect(16'h0010 + DW'(i));
    $display("test3 simultaneous push/pop when full done");

    // 4: read edges from the holding register
    load_tx(16'hBEEF);
    chk("t4_tx_busy", tx_ready, 0);
    bus_rise(1'b1, 16'h0000);
    repeat (LAT) @(posedge clk);
    #1;
    chk("t4_oe", bus_data_oe, 1);
    chk("t4_data_out", bus_data_out, 16'hBEEF);
    chk("t4_tx_ready_back", tx_ready, 1);
    bus_fall();
    chk("t4_no_underrun", underrun, 0);
    bus_rise(1'b1, 16'h0000);
    bus_fall();
    chk("t4_underrun", underrun, 1);
    @(posedge clk); #1 bus_rnw = 1'b0;
    repeat (4) @(posedge clk);
    $display("test4 read path and underrun done");

    // 5a: reset while driving the pads with a queued word
    bus_write(16'h7777);
    load_tx(16'hCAFE);
    @(posedge clk); #1 bus_rnw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_oe_before", bus_data_oe, 1);
    chk("t5_dout_before", bus_data_out, 16'hCAFE);
    pulse_reset(3);
    bus_rnw = 1'b0;
    repeat (4) @(posedge clk);
    // 5b: reset inside a write edge's sync window
    bus_rise(1'b0, 16'h9999);
    repeat (2) @(posedge clk);
    pulse_reset(2);
    repeat (12) @(posedge clk);
    #1;
    chk("t5_no_word", rx_valid, 0);
    bus_clk = 1'b0;
    repeat (6) @(posedge clk);
    $display("test5 reset mid-transfer done");

    // 6: strobe with random phase against clk
    chk_en   = 1'b0;
    rx_ready = 1'b1;
    t6       = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ((i % 2) == 0) begin
        t6_exp.push_back(16'h5A00 + DW'(i));
        bus_rnw = 1'b0;
        bus_din = 16'h5A00 + DW'(i);
        #($urandom_range(40, 70));
        bus_clk = 1'b1;
        #($urandom_range(60, 90));
        bus_clk = 1'b0;
        #($urandom_range(50, 80));
      end else begin
        load_tx(16'hC300 + DW'(i));
        bus_rnw = 1'b1;
        #($urandom_range(40, 70));
        bus_clk = 1'b1;
        #($urandom_range(60, 90));
        chk("t6_oe", bus_data_oe, 1);
        chk("t6_dout", bus_data_out, 16'hC300 + DW'(i));
        chk("t6_tx_consumed", tx_ready, 1);
        bus_clk = 1'b0;
        #($urandom_range(50, 80));
      end
    end
    repeat (20) @(posedge clk);
    #1;
    chk("t6_all_received", t6_exp.size(), 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_underrun", underrun, 0);
    $display("test6 random-phase 100 transfers done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
